// File: rtl/patp_ctrl.sv
// patp_ctrl: fetch/decode/execute sequencer for the PATP accumulator core,
// with a memory handshake, request timeout and halt at instruction boundaries.
module patp_ctrl #(
   parameter int TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       halt_req,
   input  logic [2:0] opcode,
   input  logic       acc_zero,
   input  logic       mem_ack,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_load,
   output logic       pc_load,
   output logic       pc_sel,
   output logic       acc_load,
   output logic [2:0] alu_op,
   output logic       halted,
   output logic       fault
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, FAULT} state_t;
   state_t st, nxt;
   logic [7:0] cnt;
   logic mem_op, last;
   assign mem_op = opcode inside {3'b010, 3'b110, 3'b111};
   assign last = cnt == 8'(TIMEOUT - 1);
   always_comb begin
      nxt = st;
      mem_req = 1'b0;
      mem_we = 1'b0;
      addr_sel = 1'b0;
      ir_load = 1'b0;
      pc_load = 1'b0;
      pc_sel = 1'b0;
      acc_load = 1'b0;
      alu_op = 3'b000;
      halted = 1'b0;
      fault = 1'b0;
      case (st)
         IDLE: begin
            halted = 1'b1;
            if (start) nxt = FETCH;
         end
         FETCH: begin
            mem_req = 1'b1;
            ir_load = mem_ack;
            nxt = mem_ack ? DECODE : last ? FAULT : FETCH;
         end
         DECODE: nxt = EXEC;
         EXEC:
            if (mem_op) begin
               mem_req = 1'b1;
               addr_sel = 1'b1;
               mem_we = opcode == 3'b110;
               pc_load = mem_ack;
               acc_load = mem_ack && opcode != 3'b110;
               alu_op = !acc_load ? 3'b000 : opcode == 3'b010 ? 3'b011 : 3'b100;
               if (!mem_ack && last) nxt = FAULT;
            end else begin
               pc_load = 1'b1;
               pc_sel = opcode == 3'b100 || (opcode == 3'b101 && !acc_zero);
               acc_load = opcode inside {3'b000, 3'b001, 3'b011};
               alu_op = opcode == 3'b001 ? 3'b001 : opcode == 3'b011 ? 3'b010 : 3'b000;
            end
         FAULT: fault = 1'b1;
         default: nxt = IDLE;
      endcase
      // the retiring cycle decides between the next fetch and a halt
      if (pc_load) nxt = halt_req ? IDLE : FETCH;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st <= IDLE;
         cnt <= '0;
      end else begin
         st <= nxt;
         cnt <= (nxt != st || (mem_req && mem_ack)) ? '0 : mem_req ? cnt + 8'd1 : cnt;
      end
endmodule
